// File: rtl/bank.sv
// bank: single DRAM bank storage array for the memory-system simulator.
// The array has 2**CHWIDTH rows of 2**COLWIDTH cells, and each cell is DEVICE_WIDTH bits.
// Writes are synchronous. Reads are purely combinational.
// Reset only blocks writes; it never clears the stored contents.
module bank #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_o_wr,
    input  logic [DEVICE_WIDTH-1:0] dqin,
    output logic [DEVICE_WIDTH-1:0] dqout,
    input  logic [CHWIDTH-1:0]      row,
    input  logic [COLWIDTH-1:0]     column
);

    localparam int ADDR_W = CHWIDTH + COLWIDTH;
    localparam int DEPTH  = 1 << ADDR_W;

    // The row and column are concatenated into one flat cell index.
    // Every combination maps to a distinct cell, so no bounds or wrap logic is needed.
    logic [ADDR_W-1:0]       cell_addr;
    logic                    wr_en_d;
    logic [DEVICE_WIDTH-1:0] mem_q [DEPTH];

    // Cell index and write qualification (reset suppresses the write).
    always_comb begin
        cell_addr = {row, column};
        wr_en_d   = rd_o_wr && !rst;
    end

    // Synchronous cell write. There is no reset of the contents.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[cell_addr] <= dqin;
        end
    end

    // Zero-latency read with no bypass.
    // During a same-cell write, dqout shows the old value until the edge.
    assign dqout = mem_q[cell_addr];

endmodule

// File: tb/tb_bank.sv
// tb_bank: directed self-checking bench for the bank storage model.
module tb_bank;

    localparam int W  = 4;
    localparam int CW = 10;
    localparam int RW = 5;

    logic          clk;
    logic          rst;
    logic          rd_o_wr;
    logic [W-1:0]  dqin;
    logic [W-1:0]  dqout;
    logic [RW-1:0] row;
    logic [CW-1:0] column;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    bank #(.DEVICE_WIDTH(W), .COLWIDTH(CW), .CHWIDTH(RW)) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_o_wr (rd_o_wr),
        .dqin    (dqin),
        .dqout   (dqout),
        .row     (row),
        .column  (column)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write one cell. This is entered just after a rising edge and leaves just after the next one.
    task automatic drive_write(input int r, input int c, input logic [W-1:0] d);
        row     = RW'(r);
        column  = CW'(c);
        dqin    = d;
        rd_o_wr = 1'b1;
        @(posedge clk);
        #1;
        rd_o_wr = 1'b0;
    endtask

    // Read one cell and compare it within the same cycle, then advance one cycle.
    task automatic read_check(input string tag, input int r, input int c, input logic [W-1:0] exp);
        row     = RW'(r);
        column  = CW'(c);
        rd_o_wr = 1'b0;
        #2;
        check(tag, dqout, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] d;
        rst     = 1'b1;
        rd_o_wr = 1'b0;
        dqin    = '0;
        row     = '0;
        column  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill row 1 with random data, then read it back from the scoreboard.
        for (int i = 0; i < 8; i++) begin
            d = W'($urandom_range(0, 15));
            exp_q.push_back(d);
            drive_write(1, i, d);
        end
        for (int i = 0; i < 8; i++) begin
            read_check("fill_readback", 1, i, exp_q.pop_front());
        end

        // Row isolation: the same column in different rows stays independent.
        drive_write(1, 3, 4'hA);
        drive_write(2, 3, 4'h5);
        read_check("row_iso_r1", 1, 3, 4'hA);
        read_check("row_iso_r2", 2, 3, 4'h5);

        // Reads have no side effect, even when dqin differs from the stored value.
        drive_write(0, 0, 4'hC);
        dqin = 4'h3;
        for (int i = 0; i < 4; i++) begin
            read_check("read_no_side_effect", 0, 0, 4'hC);
        end

        // Reset gating on the corner cell.
        drive_write(31, 1023, 4'h7);
        row     = 5'd31;
        column  = 10'd1023;
        dqin    = 4'h2;
        rd_o_wr = 1'b1;
        rst     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset_gate_during", dqout, 4'h7);
        end
        rst     = 1'b0;
        rd_o_wr = 1'b0;
        read_check("reset_gate_after", 31, 1023, 4'h7);

        // Writes resume on the first edge after reset.
        drive_write(31, 1023, 4'h4);
        read_check("write_after_reset", 31, 1023, 4'h4);

        // Same-cell write boundary: old value before the edge, new value after it.
        drive_write(5, 512, 4'h1);
        row     = 5'd5;
        column  = 10'd512;
        dqin    = 4'hE;
        rd_o_wr = 1'b1;
        #2;
        check("rw_same_cell_before", dqout, 4'h1);
        @(posedge clk);
        #1;
        rd_o_wr = 1'b0;
        check("rw_same_cell_after", dqout, 4'hE);

        // Extremes and aliasing onto the opposite corners.
        drive_write(0, 1023, 4'h6);
        drive_write(31, 0, 4'h9);
        drive_write(0, 0, 4'hF);
        drive_write(31, 1023, 4'h0);
        read_check("extreme_0_0", 0, 0, 4'hF);
        read_check("extreme_31_1023", 31, 1023, 4'h0);
        read_check("alias_0_1023", 0, 1023, 4'h6);
        read_check("alias_31_0", 31, 0, 4'h9);

        // Alternate write and read on consecutive cycles with no turnaround.
        drive_write(7, 100, 4'hB);
        read_check("alt_rd1", 7, 100, 4'hB);
        drive_write(7, 101, 4'h3);
        read_check("alt_rd2", 7, 101, 4'h3);
        read_check("alt_rd3", 7, 100, 4'hB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bank.md
# bank

Single DRAM bank storage model for the memory-system simulator: a two-dimensional array of `2**CHWIDTH` rows by `2**COLWIDTH` columns. Each cell holds one `DEVICE_WIDTH`-bit device word. Writes are synchronous and addressed by row/column. Reads are combinational, so the addressed word is visible on `dqout` in the same cycle the address is applied. It sits below the chip/rank level, which supplies row and column addresses and the read/write direction.

## Interface
- `DEVICE_WIDTH`, 4: data width of one cell, in bits (x4 device).
- `COLWIDTH`, 10: column address width; gives 1024 columns per row.
- `CHWIDTH`, 5: row address width; gives 32 rows.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `rd_o_wr` input 1: 1 = write the addressed cell; 0 = read (no state change).
- `dqin` input DEVICE_WIDTH: write data.
- `dqout` output DEVICE_WIDTH: read data, `mem[row][column]`.
- `row` input CHWIDTH: row address.
- `column` input COLWIDTH: column address.

## Operation
- **Storage:** `mem[0 .. 2**CHWIDTH-1][0 .. 2**COLWIDTH-1]`, each DEVICE_WIDTH bits. Total is 32×1024×4 bits at default parameters.
- **Write:** on a rising `clk` edge with `rst`=0 and `rd_o_wr`=1, `mem[row][column] <= dqin`. No other cell changes.
- **Read:** `dqout` is a continuous combinational function of the current `row`, `column` and array contents: `dqout = mem[row][column]`. There is no read enable; `dqout` is valid whenever the address is stable, including during write cycles.
- **Reset:**
  - With `rst`=1 at a rising edge, the write is suppressed regardless of `rd_o_wr`.
  - Array contents are not cleared by reset. Reset only gates writes, so no per-cell reset fan-out is needed.
  - `dqout` has no dedicated reset value; it always reflects the addressed cell.
- **Power-up:** array contents are X in simulation until written. Bench checks only previously written cells.
- **Addressing:** all addresses are in range by construction, because the array depth is exactly a power of two. There is no bounds logic and no wrap-around.
- **No row buffer and no activate/precharge state:** any row/column may be accessed on any cycle. Command timing (tRCD, tRAS, etc.) is enforced by the controller above this block.

## Timing
- **Write latency:** the data is in the array after the rising edge that samples `rd_o_wr`=1. A read of the same cell shows the new value from that edge onward.
- **Read latency:** zero cycles from address change to `dqout`, combinational only.
- **Read-during-write, same cell:** `dqout` shows the old contents before the edge and the new `dqin` after the edge. No bypass of `dqin` to `dqout` before the edge.
- **Back-to-back writes:** one write per cycle, every cycle; no bubbles are required.
- **Write then read:** a read of a cell written in cycle N returns that data in cycle N+1.
- **Reset mid-operation:** a write coincident with a `rst`=1 edge is dropped. Writes resume on the first edge with `rst`=0. Existing contents are preserved.
- **Simultaneous events:** `rd_o_wr` toggling on consecutive cycles alternates write and read without any turnaround cycle.

## Test plan
- **Fill and read back:** write `rd_o_wr`=1, `row`=1, `column`=0..7 with random 4-bit `dqin`, one per cycle. Then read `row`=1, `column`=0..7, one per cycle. `dqout` must equal the stored value for each column.
- **Row isolation:** write 4'hA to (row 1, col 3) and 4'h5 to (row 2, col 3). Reading (1,3) must give 4'hA; reading (2,3) must give 4'h5.
- **Read has no side effect:** write 4'hC to (0,0), then hold `rd_o_wr`=0 with `dqin`=4'h3 for 4 cycles at (0,0). `dqout` must stay 4'hC.
- **Reset gating:**
  - Write 4'h7 to (31,1023), the corner cell.
  - Assert `rst` with `rd_o_wr`=1, `dqin`=4'h2 at the same address for 2 cycles.
  - `dqout` must remain 4'h7 during and after reset.
- **Same-cell write/read boundary:** with (5,512) holding 4'h1, apply a write of 4'hE. `dqout` must be 4'h1 before the edge and 4'hE immediately after it.
- **Extremes:** write 4'hF to (0,0) and 4'h0 to (31,1023). Read both back correctly, and confirm no aliasing onto (0,1023) or (31,0).
